// File: rtl/clock_enable_gen.sv
// PLL lock supervisor plus phase-aligned, runtime-programmable clock-enable strobes.
// Latency: ready/sys_rst_n rise 3+LOCK_CYCLES+RST_HOLD edges after lock is first sampled; fall 3 edges after lock loss.
// Backpressure: none; div_load is always accepted and acknowledged one cycle later.
module clock_enable_gen #(
    parameter int NUM_CH      = 2,
    parameter int DIV_WIDTH   = 8,
    parameter int LOCK_CYCLES = 1024,
    parameter int RST_HOLD    = 16,
    parameter int DIV_RESET   = 1
) (
    input  logic                        clock_in,
    input  logic                        reset_n,
    input  logic                        pll_locked,
    input  logic [NUM_CH*DIV_WIDTH-1:0] div_value,
    input  logic                        div_load,
    output logic                        load_ack,
    output logic [NUM_CH-1:0]           clk_en,
    output logic                        sys_rst_n,
    output logic                        ready
);
    localparam int LCW = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
    localparam int HCW = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
    localparam logic [LCW-1:0] LOCK_LAST = LCW'(LOCK_CYCLES - 1);
    localparam logic [HCW-1:0] HOLD_LAST = HCW'(RST_HOLD - 1);

    typedef enum logic [1:0] {WAIT_LOCK, STABLE, HOLD, RUN} state_t;

    state_t         state, state_nxt;
    logic [LCW-1:0] lock_cnt, lock_cnt_nxt;
    logic [HCW-1:0] hold_cnt, hold_cnt_nxt;
    logic           lock_meta, lock_s;
    logic           run_en;

    logic [DIV_WIDTH-1:0] div_q   [NUM_CH];
    logic [DIV_WIDTH-1:0] cnt_q   [NUM_CH];
    logic [DIV_WIDTH-1:0] div_eff [NUM_CH];
    logic [DIV_WIDTH-1:0] cnt_eff [NUM_CH];
    logic [DIV_WIDTH-1:0] cnt_nxt [NUM_CH];
    logic [NUM_CH-1:0]    clk_en_nxt;

    // Outputs are gated by the live lock so a loss in RUN drops them on the same edge the FSM leaves RUN.
    assign run_en = (state == RUN) && lock_s;

    always_ff @(posedge clock_in) begin
        if (!reset_n) begin
            state    <= WAIT_LOCK;
            lock_cnt <= '0;
            hold_cnt <= '0;
        end else begin
            state    <= state_nxt;
            lock_cnt <= lock_cnt_nxt;
            hold_cnt <= hold_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        lock_cnt_nxt = lock_cnt;
        hold_cnt_nxt = hold_cnt;
        case (state)
            WAIT_LOCK: begin
                if (lock_s) begin
                    state_nxt    = STABLE;
                    lock_cnt_nxt = '0;
                end
            end
            STABLE: begin
                if (!lock_s) begin
                    state_nxt = WAIT_LOCK;
                end else if (lock_cnt == LOCK_LAST) begin
                    state_nxt    = HOLD;
                    hold_cnt_nxt = '0;
                end else begin
                    lock_cnt_nxt = lock_cnt + LCW'(1);
                end
            end
            HOLD: begin
                if (!lock_s) begin
                    state_nxt = WAIT_LOCK;
                end else if (hold_cnt == HOLD_LAST) begin
                    state_nxt = RUN;
                end else begin
                    hold_cnt_nxt = hold_cnt + HCW'(1);
                end
            end
            RUN: begin
                if (!lock_s) state_nxt = WAIT_LOCK;
            end
            default: state_nxt = WAIT_LOCK;
        endcase
    end

    // A load restarts every counter from zero with the new divisor, so the strobe lands the cycle after capture.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            div_eff[i]    = div_load ? div_value[i*DIV_WIDTH +: DIV_WIDTH] : div_q[i];
            cnt_eff[i]    = div_load ? '0 : cnt_q[i];
            clk_en_nxt[i] = run_en && (div_eff[i] != '0) && (cnt_eff[i] == '0);
            if (!run_en || (div_eff[i] == '0) || (cnt_eff[i] == div_eff[i] - DIV_WIDTH'(1)))
                cnt_nxt[i] = '0;
            else
                cnt_nxt[i] = cnt_eff[i] + DIV_WIDTH'(1);
        end
    end

    always_ff @(posedge clock_in) begin
        if (!reset_n) begin
            lock_meta <= 1'b0;
            lock_s    <= 1'b0;
            load_ack  <= 1'b0;
            clk_en    <= '0;
            sys_rst_n <= 1'b0;
            ready     <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                div_q[i] <= DIV_WIDTH'(DIV_RESET);
                cnt_q[i] <= '0;
            end
        end else begin
            lock_meta <= pll_locked;
            lock_s    <= lock_meta;
            load_ack  <= div_load;
            clk_en    <= clk_en_nxt;
            sys_rst_n <= run_en;
            ready     <= run_en;
            for (int i = 0; i < NUM_CH; i++) begin
                if (div_load) div_q[i] <= div_value[i*DIV_WIDTH +: DIV_WIDTH];
                cnt_q[i] <= cnt_nxt[i];
            end
        end
    end
endmodule

// File: doc/clock_enable_gen.md
Name: clock_enable_gen

Overview:
- Parametrised clock-management successor block, running entirely in the fast PLL output clock domain (e.g. 240 MHz).
- Supervises the PLL lock signal through a synchroniser, a stability filter and a sequenced downstream reset.
- Generates NUM_CH phase-aligned, runtime-programmable clock-enable strobes (pixel, audio, UART ticks), so consumers stay on one clock with no derived clocks.

Parameters:
- NUM_CH, 2, number of clock-enable channels (1..8)
- DIV_WIDTH, 8, divisor width per channel
- LOCK_CYCLES, 1024, consecutive synchronised-locked cycles required before leaving lock filtering (>=1)
- RST_HOLD, 16, cycles sys_rst_n is held low after lock is deemed stable (>=1)
- DIV_RESET, 1, divisor value loaded into every channel on reset

Ports:
- clock_in  input  1  fast clock (PLL output)
- reset_n  input  1  synchronous active-low reset
- pll_locked  input  1  raw PLL lock, asynchronous; 2-flop synchronised internally (lock_s)
- div_value  input  NUM_CH*DIV_WIDTH  channel i divisor at [i*DIV_WIDTH +: DIV_WIDTH]
- div_load  input  1  single-cycle pulse; capture div_value
- load_ack  output  1  single-cycle pulse; new divisors active
- clk_en  output  NUM_CH  per-channel one-cycle enable strobes
- sys_rst_n  output  1  sequenced active-low reset for downstream logic
- ready  output  1  high only in state RUN

Behaviour:
- Reset (reset_n=0 at an edge):
  - state=WAIT_LOCK; synchroniser flops cleared.
  - All divisors=DIV_RESET; channel counters=0.
  - clk_en=0, load_ack=0, sys_rst_n=0, ready=0.
- FSM, one transition per edge:
  - WAIT_LOCK: lock_s=1 -> STABLE, lock counter=0.
  - STABLE: lock_s=0 -> WAIT_LOCK. Counter reaching LOCK_CYCLES-1 -> HOLD, hold counter=0.
  - HOLD: sys_rst_n=0. lock_s=0 -> WAIT_LOCK. Counter reaching RST_HOLD-1 -> RUN.
  - RUN: sys_rst_n=1, ready=1. lock_s=0 -> WAIT_LOCK; sys_rst_n=0, ready=0 and clk_en=0 all take effect the same edge.
- Lock latency: the edge where pll_locked is first sampled high is edge 0. ready and sys_rst_n first read 1 after edge 3+LOCK_CYCLES+RST_HOLD, provided lock stays high. Any lock glitch restarts the filter from zero.
- All outputs are registered.
- Counter widths are $clog2 of their limits, minimum 1 bit.
- Divider, per channel i with divisor D (held in an active register):
  - D=0: channel disabled; clk_en[i] never asserts; counter held at 0.
  - D=1: clk_en[i]=1 every RUN cycle.
  - D>=2: clk_en[i] asserts once every D cycles, exactly one cycle wide.
  - Counter wraps D-1 -> 0; strobe is registered on the wrap.
- Phase alignment: on entry to RUN, all counters start so every enabled channel strobes in the first RUN cycle, i.e. the same cycle ready first reads 1.
- Outside RUN: counters are held at 0 and clk_en=0.
- div_load:
  - At the sampling edge, div_value is copied into the active registers.
  - All counters restart so every enabled channel strobes in the following cycle. That cycle is the re-alignment point.
  - load_ack pulses in that same following cycle.
  - Outside RUN: registers update and load_ack pulses, but no strobes occur.
  - div_load on consecutive cycles: each is honoured, the last value wins, and load_ack pulses each cycle.
- Simultaneous events:
  - Lock loss plus div_load: divisors are still captured and load_ack still pulses, but the state goes to WAIT_LOCK and clk_en=0.
  - reset_n=0 overrides everything, including mid-HOLD or mid-RUN.
- sys_rst_n is never high outside RUN.

Test Plan:
1. NUM_CH=2, LOCK_CYCLES=8, RST_HOLD=4, DIV_RESET=1; pll_locked=1 from edge 0 -> ready and sys_rst_n rise after edge 15. clk_en=2'b11 from that cycle and every cycle after.
2. Lock glitch: drop pll_locked for 1 cycle during STABLE at count 5 -> FSM returns to WAIT_LOCK. After lock returns, ready rises a full 3+8+4 edges later; no early release.
3. In RUN, load div_value={ch1=3, ch0=5} -> load_ack pulses the next cycle. ch0 strobes at t, t+5, t+10; ch1 at t, t+3, t+6, with t the ack cycle. No double or missing strobe.
4. Load ch0=0, ch1=1 -> clk_en[0] stays 0 indefinitely; clk_en[1] is high every cycle.
5. In RUN, pll_locked falls -> after synchroniser latency (2 edges) plus one FSM edge, ready=0, sys_rst_n=0, clk_en=0 together. Relock repeats the full sequence.
6. reset_n=0 for one edge mid-RUN with ch0=5 loaded -> all outputs 0. Divisors return to DIV_RESET=1, confirmed by 1-cycle strobes after the relock sequence.
